// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal datapath blocks.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_BASE = 4'd10;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit subtract with borrow: diff = a - b - bin, folded back into 0..9.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] t;

    // Five bits hold a - b - bin for any 4-bit inputs; bit 4 is the sign.
    always_comb begin
        t    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        bout = t[4];
        diff = bout ? (t[3:0] + BCD_BASE) : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor A - B, LSD first. Collects the raw difference
// into a buffer, then emits sign plus magnitude, complementing on the fly
// when the result is negative.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_last,
    output logic       out_neg,
    output logic       out_err
);

    // Count/n must reach DIGITS, so they are one bit wider than the index.
    localparam int CW = $clog2(DIGITS + 1);
    localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t     state, state_nxt;
    bcd_digit_t dbuf [DIGITS];
    logic [CW-1:0] count, n, idx;
    logic       borrow, err, neg, c, c_nxt;

    logic       accept, emit_hs, last_in, last_out;
    bcd_digit_t diff, cur, d9;
    logic       bout, cmp_bout;

    assign accept   = in_valid & in_ready;
    assign emit_hs  = out_valid & out_ready;
    assign last_in  = in_last | (count == CW'(DIGITS - 1));
    assign last_out = (idx == n - CW'(1));
    assign cur      = dbuf[idx[AW-1:0]];

    // Collect-side digit subtract.
    bcd_digit_sub u_sub (
        .a    (a),
        .b    (b),
        .bin  (borrow),
        .diff (diff),
        .bout (bout)
    );

    // Emit-side nines' complement of the stored digit (9 - d).
    bcd_digit_sub u_cmp (
        .a    (BCD_MAX),
        .b    (cur),
        .bin  (1'b0),
        .diff (d9),
        .bout (cmp_bout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next-state: leave COLLECT on the last accept, leave EMIT on the last handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && last_in)   state_nxt = EMIT;
            EMIT:    if (emit_hs && last_out) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Outputs and the serial ten's-complement step (9 - d + c).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_digit = 4'd0;
        out_last  = 1'b0;
        out_neg   = 1'b0;
        out_err   = 1'b0;
        c_nxt     = c;
        case (state)
            COLLECT: in_ready = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                out_last  = last_out;
                out_neg   = neg & last_out;
                out_err   = err & last_out;
                if (neg) begin
                    // 9 - d + 1 overflows only when d == 0; carry then ripples on.
                    if (c && (d9 == BCD_MAX) && !cmp_bout) begin
                        out_digit = 4'd0;
                        c_nxt     = 1'b1;
                    end else begin
                        out_digit = d9 + {3'b000, c};
                        c_nxt     = 1'b0;
                    end
                end else begin
                    out_digit = cur;
                end
            end
            default: ;
        endcase
    end

    // Control registers: borrow chain, digit count, error flag, emit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow <= 1'b0;
            count  <= '0;
            err    <= 1'b0;
            neg    <= 1'b0;
            n      <= '0;
            idx    <= '0;
            c      <= 1'b0;
        end else if (accept) begin
            borrow <= bout;
            count  <= count + CW'(1);
            err    <= err | (a > BCD_MAX) | (b > BCD_MAX);
            if (last_in) begin
                neg <= bout;
                n   <= count + CW'(1);
                idx <= '0;
                c   <= 1'b1;
            end
        end else if (emit_hs) begin
            idx <= idx + CW'(1);
            c   <= c_nxt;
            if (last_out) begin
                borrow <= 1'b0;
                count  <= '0;
                err    <= 1'b0;
            end
        end
    end

    // Raw difference buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept) dbuf[count[AW-1:0]] <= diff;
    end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed bench for bcd_serial_sub: hand-computed differences, forced last,
// backpressure, error flag and mid-emit reset.
module tb_bcd_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [3:0] a, b;
    logic       out_valid, out_ready;
    logic [3:0] out_digit;
    logic       out_last, out_neg, out_err;

    int compared   = 0;
    int mismatched = 0;

    bcd_serial_sub #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one digit pair and hold it until accepted (bounded).
    task automatic push(input logic [3:0] av, input logic [3:0] bv, input logic lst);
        int k;
        in_valid = 1'b1; a = av; b = bv; in_last = lst;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin step(); k++; end
        chk("in_ready_wait", in_ready, 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Check the presented result digit, then handshake it.
    task automatic pop(input string tag, input logic [3:0] d, input logic lst,
                       input logic ng, input logic er);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin step(); k++; end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_digit"}, out_digit, d);
        chk({tag, "_last"}, out_last, lst);
        if (lst) begin
            chk({tag, "_neg"}, out_neg, ng);
            chk({tag, "_err"}, out_err, er);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = 4'd0; b = 4'd0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_digit", out_digit, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_neg", out_neg, 0);
        chk("rst_out_err", out_err, 0);
        rst = 1'b0;
        step();

        // 42 - 17 = 25
        push(4'd2, 4'd7, 1'b0);
        push(4'd4, 4'd1, 1'b1);
        chk("p1_latency_valid", out_valid, 1);
        chk("p1_in_ready_low", in_ready, 0);
        pop("p1_d0", 4'd5, 1'b0, 1'b0, 1'b0);
        pop("p1_d1", 4'd2, 1'b1, 1'b0, 1'b0);
        chk("p1_back_collect", in_ready, 1);
        chk("p1_out_valid_low", out_valid, 0);

        // 17 - 42 = -25 (raw 75)
        push(4'd7, 4'd2, 1'b0);
        push(4'd1, 4'd4, 1'b1);
        pop("p2_d0", 4'd5, 1'b0, 1'b0, 1'b0);
        pop("p2_d1", 4'd2, 1'b1, 1'b1, 1'b0);

        // 0000 - 0001 = -0001 (raw 9999), explicit last
        push(4'd0, 4'd1, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b1);
        pop("p3_d0", 4'd1, 1'b0, 1'b0, 1'b0);
        pop("p3_d1", 4'd0, 1'b0, 1'b0, 1'b0);
        pop("p3_d2", 4'd0, 1'b0, 1'b0, 1'b0);
        pop("p3_d3", 4'd0, 1'b1, 1'b1, 1'b0);

        // Same operands, in_last never asserted: forced last at DIGITS
        push(4'd0, 4'd1, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b0);
        chk("p4_forced_valid", out_valid, 1);
        chk("p4_forced_in_ready", in_ready, 0);
        pop("p4_d0", 4'd1, 1'b0, 1'b0, 1'b0);
        pop("p4_d1", 4'd0, 1'b0, 1'b0, 1'b0);
        pop("p4_d2", 4'd0, 1'b0, 1'b0, 1'b0);
        pop("p4_d3", 4'd0, 1'b1, 1'b1, 1'b0);

        // 30 - 30 = 0, never negative zero
        push(4'd0, 4'd0, 1'b0);
        push(4'd3, 4'd3, 1'b1);
        pop("p5_d0", 4'd0, 1'b0, 1'b0, 1'b0);
        pop("p5_d1", 4'd0, 1'b1, 1'b0, 1'b0);

        // Single digit 5 - 5
        push(4'd5, 4'd5, 1'b1);
        pop("p6_d0", 4'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure on 17 - 42
        push(4'd7, 4'd2, 1'b0);
        push(4'd1, 4'd4, 1'b1);
        pop("p7_d0", 4'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("p7_hold_valid", out_valid, 1);
            chk("p7_hold_digit", out_digit, 4'd2);
            chk("p7_hold_last", out_last, 1);
            chk("p7_hold_neg", out_neg, 1);
            chk("p7_hold_in_ready", in_ready, 0);
            step();
        end
        pop("p7_d1", 4'd2, 1'b1, 1'b1, 1'b0);
        chk("p7_back_collect", in_ready, 1);

        // Non-BCD minuend digit flags the error on the last beat
        push(4'hA, 4'd0, 1'b1);
        chk("p8_valid", out_valid, 1);
        chk("p8_last", out_last, 1);
        chk("p8_err", out_err, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("p8_back_collect", in_ready, 1);

        // Reset during EMIT, then a clean 9 - 3
        push(4'd2, 4'd7, 1'b0);
        push(4'd4, 4'd1, 1'b1);
        chk("p9_in_emit", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("p9_rst_out_valid", out_valid, 0);
        chk("p9_rst_in_ready", in_ready, 1);
        push(4'd9, 4'd3, 1'b1);
        pop("p9_d0", 4'd6, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
